// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with valid/ready skid buffer, flush, optional stall counter (ID_EX_STALL_CNT_EN)
module id_ex_stage_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_exec_command,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_wb_en,
    input  logic        in_branch,
    input  logic        in_status_update_en,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_val_rn,
    input  logic [31:0] in_val_rm,
    input  logic        in_imm,
    input  logic [11:0] in_shift_operand,
    input  logic [23:0] in_signed_imm_24,
    input  logic [3:0]  in_dest,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_exec_command,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_wb_en,
    output logic        out_branch,
    output logic        out_status_update_en,
    output logic [31:0] out_pc,
    output logic [31:0] out_val_rn,
    output logic [31:0] out_val_rm,
    output logic        out_imm,
    output logic [11:0] out_shift_operand,
    output logic [23:0] out_signed_imm_24,
    output logic [3:0]  out_dest,
    output logic        out_carry,
    output logic [15:0] stall_count
);
    logic [146:0] in_pay, main_pay, skid_pay;
    logic         main_valid, skid_valid, accept, send;
    logic         c_mem_read, c_mem_write, c_wb_en, c_branch, c_status;

    assign in_pay = {in_exec_command, in_mem_read, in_mem_write, in_wb_en, in_branch, in_status_update_en,
                     in_pc, in_val_rn, in_val_rm, in_imm, in_shift_operand, in_signed_imm_24, in_dest, in_carry};
    assign {out_exec_command, c_mem_read, c_mem_write, c_wb_en, c_branch, c_status,
            out_pc, out_val_rn, out_val_rm, out_imm, out_shift_operand, out_signed_imm_24, out_dest, out_carry} = main_pay;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign send      = main_valid && out_ready;

    assign out_mem_read         = c_mem_read  && main_valid;
    assign out_mem_write        = c_mem_write && main_valid;
    assign out_wb_en            = c_wb_en     && main_valid;
    assign out_branch           = c_branch    && main_valid;
    assign out_status_update_en = c_status    && main_valid;

    // Main/skid entries: refill main from skid first to keep order; flush squashes both and any new item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pay   <= '0;
            skid_pay   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || send) begin
            if (skid_valid) begin
                main_pay   <= skid_pay;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_pay   <= in_pay;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_pay   <= in_pay;
            skid_valid <= 1'b1;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Count cycles where a valid item is held by downstream backpressure, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (main_valid && !out_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = 16'h0000;
`endif
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_exec_command in 4; in_mem_read, in_mem_write, in_wb_en, in_branch, in_status_update_en in 1 each.
REQ-003 SHALL have upstream data ports: in_pc in 32; in_val_rn in 32; in_val_rm in 32; in_imm in 1; in_shift_operand in 12; in_signed_imm_24 in 24; in_dest in 4; in_carry in 1.
REQ-004 SHALL have downstream ports: out_valid out 1; out_ready in 1; out_* mirrors of every in_* payload field, same widths.
REQ-005 SHALL have flush in 1 (branch-taken squash) and stall_count out 16.

Function
REQ-006 SHALL hold two entries: main (drives out_*) and skid; each has a valid bit; payload is 147 bits.
REQ-007 SHALL drive in_ready = !skid_valid, from a register only (no combinational path from out_ready).
REQ-008 SHALL define accept = in_valid && in_ready; send = out_valid && out_ready; out_valid = main_valid.
REQ-009 SHALL, when main empty or send: load main from skid if skid_valid (skid cleared), else from input if accept; else main_valid cleared.
REQ-010 SHALL, when main full and not send and accept: load skid from input.
REQ-011 SHALL give latency of one cycle: item accepted at edge N appears on out_* with out_valid=1 after edge N.
REQ-012 SHALL preserve order; no item dropped or duplicated under any out_ready pattern.
REQ-013 SHALL sustain one item per cycle while out_ready=1.
REQ-014 SHALL, on flush=1 at an edge, clear main_valid and skid_valid; an item accepted that same cycle is discarded; flush overrides REQ-009/010.
REQ-015 SHALL gate out_mem_read, out_mem_write, out_wb_en, out_branch, out_status_update_en with out_valid (zero when empty); data fields hold last value.
REQ-016 SHALL hold main payload stable while out_valid=1 and out_ready=0.
REQ-017 SHALL treat in_valid=0 as no transfer regardless of payload content.

Reset
REQ-018 SHALL on rst_n=0 immediately clear main_valid, skid_valid, all payload registers, stall_count.
REQ-019 SHALL drive after reset: out_valid=0, in_ready=1, all out_* = 0, stall_count=0.
REQ-020 SHALL, on reset mid-stall, discard both entries; first edge after rst_n rises behaves as empty pipeline.

Configuration
REQ-021 SHALL use macro ID_EX_STALL_CNT_EN.
REQ-022 SHALL with macro defined: stall_count increments by 1 each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, unaffected by flush.
REQ-023 SHALL without macro: stall_count tied to 16'h0000, no counter logic.

Verification
REQ-024 Reset: rst_n=0 mid-cycle with both entries full -> out_valid=0, in_ready=1, out_wb_en=0 immediately.
REQ-025 Streaming: out_ready=1, in_pc=0,4,8,12 on consecutive cycles -> out_pc=0,4,8,12 one cycle later, in_ready stays 1.
REQ-026 Backpressure: out_ready=0 with pc=0x10,0x14,0x18 offered -> 0x10 held on out, 0x14 in skid, in_ready=0, 0x18 not accepted; out_ready=1 -> 0x10,0x14,0x18 emitted in order.
REQ-027 Flush: both entries full, flush=1 with in_valid=1 pc=0x20 -> next cycle out_valid=0, out_mem_write=0, in_ready=1; 0x20 never emitted.
REQ-028 Counter (macro on): out_valid=1, out_ready=0 for 5 cycles -> stall_count=5; force 70000 stall cycles -> 16'hFFFF; macro off -> 0.
REQ-029 Bubble: in_valid=0 with in_wb_en=1 -> out_valid=0, out_wb_en=0.
